// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// Each SHIFT cycle moves one bit from the BCD register into the binary
// register. Digits that read 8 or more after the shift are reduced by 3.
// Digits above 9 are rejected up front with err and no shifting.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    // True when any 4-bit digit of v holds a non-decimal code (> 9).
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Per-digit correction after a right shift: a digit >= 8 received a
    // borrowed bit worth 8 that should only be worth 5, so subtract 3.
    // Each digit is handled on its own; nothing carries between digits.
    function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [BCD_W-1:0] bcd_q,     bcd_d;
    logic [BIN_W-1:0] bin_q,     bin_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             errp_q,    errp_d;
    logic [BIN_W-1:0] bin_out_q, bin_out_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;
    logic             err_q,     err_d;
    logic             ovf_q,     ovf_d;
    logic [BCD_W+BIN_W-1:0] cat_s;

    // Next-state and datapath logic for the IDLE/SHIFT/FIN sequence.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        errp_d    = errp_q;
        bin_out_d = bin_out_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ovf_d     = ovf_q;
        cat_s     = {bcd_q, bin_q} >> 1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (has_bad_digit(bcd_in)) begin
                        errp_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        errp_d  = 1'b0;
                        bcd_d   = bcd_in;
                        bin_d   = {BIN_W{1'b0}};
                        cnt_d   = CNT_W'(BIN_W);
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bcd_d = fix_digits(cat_s[BCD_W+BIN_W-1:BIN_W]);
                bin_d = cat_s[BIN_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (errp_q) begin
                    bin_out_d = {BIN_W{1'b0}};
                    ovf_d     = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    bin_out_d = bin_q;
                    ovf_d     = (bcd_q != {BCD_W{1'b0}});
                    err_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; reset discards any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bcd_q     <= {BCD_W{1'b0}};
            bin_q     <= {BIN_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            errp_q    <= 1'b0;
            bin_out_q <= {BIN_W{1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            errp_q    <= errp_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bin_out = bin_out_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard testbench for bcd_to_bin_seq: stimulus pushes the expected
// result and the expected done cycle; a monitor pops on every done pulse.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic [7:0]  bin_out;
    logic        done;
    logic        busy;
    logic        err;
    logic        ovf;

    typedef struct packed {
        logic [7:0]  bin;
        logic        err;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 32'd0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .done    (done),
        .busy    (busy),
        .err     (err),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp accepted starts and done pulses.
    always @(posedge clk) cyc = cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample just after each rising edge, compare on done.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("bin_out", {24'd0, bin_out}, {24'd0, e.bin});
                    chk("err",     {31'd0, err},     {31'd0, e.err});
                    chk("ovf",     {31'd0, ovf},     {31'd0, e.ovf});
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    // Wait (bounded) for an idle negedge, issue a one-cycle start, push expectation.
    task automatic conv(input logic [11:0] b, input logic [7:0] eb,
                        input logic e_err, input logic e_ovf);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
        bcd_in = b;
        start  = 1'b1;
        e.bin  = eb;
        e.err  = e_err;
        e.ovf  = e_ovf;
        e.cyc  = cyc + 32'd1 + (e_err ? 32'd1 : 32'd9);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stimulus.
    initial begin
        exp_t e;
        logic [31:0] base;
        logic [11:0] enc;
        int n;

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (2) @(negedge clk);
        chk("rst_bin_out", {24'd0, bin_out}, 32'd0);
        chk("rst_done",    {31'd0, done},    32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_err",     {31'd0, err},     32'd0);
        chk("rst_ovf",     {31'd0, ovf},     32'd0);
        rst = 1'b0;

        // Valid maximum, plus busy profile across the conversion.
        conv(12'h255, 8'hFF, 1'b0, 1'b0);
        chk("busy_run", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_run", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("done_after", {31'd0, done}, 32'd1);

        // Overflow cases.
        conv(12'h256, 8'h00, 1'b0, 1'b1);
        conv(12'h999, 8'hE7, 1'b0, 1'b1);
        conv(12'h000, 8'h00, 1'b0, 1'b0);
        conv(12'h100, 8'h64, 1'b0, 1'b0);

        // Invalid digit, then a clean zero.
        conv(12'h0A5, 8'h00, 1'b1, 1'b0);
        conv(12'hF00, 8'h00, 1'b1, 1'b0);
        conv(12'h000, 8'h00, 1'b0, 1'b0);

        // Encoder round trip over all bytes.
        for (int b = 0; b < 256; b++) begin
            enc = {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
            conv(enc, 8'(b), 1'b0, 1'b0);
        end

        // start held high: accepted every 10 cycles.
        @(negedge clk);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        bcd_in = 12'h128;
        start  = 1'b1;
        base   = cyc + 32'd1;
        for (int k = 0; k < 3; k++) begin
            e.bin = 8'h80;
            e.err = 1'b0;
            e.ovf = 1'b0;
            e.cyc = base + 32'd9 + 32'(k * 10);
            sb.push_back(e);
        end
        repeat (21) @(negedge clk);
        start = 1'b0;

        // Start pulse mid-SHIFT with different operand is ignored.
        conv(12'h042, 8'h2A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bcd_in = 12'h999;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;

        // Reset four cycles into a conversion of 200.
        conv(12'h200, 8'hC8, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",    {31'd0, busy},    32'd0);
        chk("mid_rst_done",    {31'd0, done},    32'd0);
        chk("mid_rst_bin_out", {24'd0, bin_out}, 32'd0);
        chk("mid_rst_err",     {31'd0, err},     32'd0);
        chk("mid_rst_ovf",     {31'd0, ovf},     32'd0);
        e = sb.pop_back();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        conv(12'h042, 8'h2A, 1'b0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
